// File: rtl/square_animator.sv
// square_animator
//   Frame-paced square sprite animator. Each accepted tick_en erases the
//   SIZE x SIZE square at its current position, moves it STEP pixels per axis
//   with edge bounce, then redraws it, streaming one pixel per cycle into a
//   VGA adapter write port.
//
//   Sequence: IDLE -> ERASE (SIZE*SIZE plots, BG) -> UPDATE (1 cycle)
//             -> DRAW (SIZE*SIZE plots, FG) -> DONE (1 cycle, frame_done) -> IDLE
//
// Ports
//   clock       in   system clock
//   reset       in   synchronous, active-low
//   tick_en     in   frame enable, sampled every cycle
//   x_out       out  [7:0] pixel x
//   y_out       out  [6:0] pixel y
//   colour      out  [2:0] pixel colour
//   plot        out  write strobe, one pixel per high cycle
//   busy        out  frame sequence in progress
//   frame_done  out  one-cycle pulse in the DONE cycle
//   state_dbg   out  [2:0] current FSM state (debug observation only)
//
// Handshake: tick_en is a level sampled each cycle; a frame starts when it is
//   high in IDLE. The write port has no back-pressure: every cycle with
//   plot=1 carries exactly one pixel (x_out, y_out, colour).
//
// Build option: define TICK_LATCH_EN to remember one tick_en seen while busy
//   and start the next frame straight from DONE (busy stays high). Without
//   it, tick_en is ignored outside IDLE.
//
// All outputs are registered.

module square_animator #(
  parameter int         SIZE   = 4,
  parameter int         X_MAX  = 160,
  parameter int         Y_MAX  = 120,
  parameter int         X_INIT = 0,
  parameter int         Y_INIT = 0,
  parameter int         STEP   = 1,
  parameter logic [2:0] FG     = 3'b111,
  parameter logic [2:0] BG     = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_en,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] state_dbg
);

  localparam int PW = $clog2(SIZE);
  localparam int CW = 2 * PW;
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE * SIZE - 1);
  localparam logic [8:0] X_LIM  = 9'(X_MAX - SIZE);
  localparam logic [8:0] Y_LIM  = 9'(Y_MAX - SIZE);
  localparam logic [8:0] STEP9  = 9'(STEP);
  localparam logic [7:0] X_STEP = 8'(STEP);
  localparam logic [6:0] Y_STEP = 7'(STEP);
  localparam logic [7:0] X_RST  = 8'(X_INIT);
  localparam logic [6:0] Y_RST  = 7'(Y_INIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_UPDATE = 3'd2,
    S_DRAW   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic        dx_neg_q, dx_neg_d;
  logic        dy_neg_q, dy_neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  x_out_q, x_out_d;
  logic [6:0]  y_out_q, y_out_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
`ifdef TICK_LATCH_EN
  logic        pend_q, pend_d;
`endif

  // Pixel counter: low half is the column (fastest), high half the row.
  logic [PW-1:0] px, py;
  logic [8:0]    x9, y9;
  assign px = cnt_q[PW-1:0];
  assign py = cnt_q[CW-1:PW];
  assign x9 = {1'b0, x_q};
  assign y9 = {2'b00, y_q};

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dx_neg_d     = dx_neg_q;
    dy_neg_d     = dy_neg_q;
    cnt_d        = cnt_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    busy_d       = 1'b1;
    frame_done_d = 1'b0;
`ifdef TICK_LATCH_EN
    pend_d       = pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (tick_en) state_d = S_ERASE;
      end
      S_ERASE, S_DRAW: begin
        plot_d   = 1'b1;
        colour_d = (state_q == S_ERASE) ? BG : FG;
        x_out_d  = x_q + 8'(px);
        y_out_d  = y_q + 7'(py);
        // Counter spans exactly SIZE*SIZE values, so it wraps to 0 on exit.
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = (state_q == S_ERASE) ? S_UPDATE : S_DRAW_EXIT();
      end
      S_UPDATE: begin
        // Bounce decisions use 9 bits so x+STEP cannot wrap.
        if (!dx_neg_q) begin
          if (x9 + STEP9 > X_LIM) begin dx_neg_d = 1'b1; x_d = x_q - X_STEP; end
          else                         x_d = x_q + X_STEP;
        end else begin
          if (x9 < STEP9) begin dx_neg_d = 1'b0; x_d = x_q + X_STEP; end
          else                 x_d = x_q - X_STEP;
        end
        if (!dy_neg_q) begin
          if (y9 + STEP9 > Y_LIM) begin dy_neg_d = 1'b1; y_d = y_q - Y_STEP; end
          else                         y_d = y_q + Y_STEP;
        end else begin
          if (y9 < STEP9) begin dy_neg_d = 1'b0; y_d = y_q + Y_STEP; end
          else                 y_d = y_q - Y_STEP;
        end
        state_d = S_DRAW;
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
`ifdef TICK_LATCH_EN
        // A remembered tick, or one arriving now, chains the next frame.
        if (pend_q || tick_en) begin
          pend_d  = 1'b0;
          state_d = S_ERASE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef TICK_LATCH_EN
    if ((state_q == S_ERASE || state_q == S_UPDATE || state_q == S_DRAW) && tick_en)
      pend_d = 1'b1;
`endif
  end

  // DRAW always finishes into DONE; kept as a function so the ERASE/DRAW
  // shared branch reads as one line.
  function automatic state_t S_DRAW_EXIT();
    return S_DONE;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      x_q          <= X_RST;
      y_q          <= Y_RST;
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      cnt_q        <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef TICK_LATCH_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dx_neg_q     <= dx_neg_d;
      dy_neg_q     <= dy_neg_d;
      cnt_q        <= cnt_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef TICK_LATCH_EN
      pend_q       <= pend_d;
`endif
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_square_animator.sv
// Testbench for square_animator.
//   u_main: default parameters, checked every cycle against a frame-level
//           reference model (expected-output queue).
//   u_bnc : starts at the right/bottom edge to exercise the +1 -> -1 bounce.
//   u_stp : STEP=2 on a small field to exercise the -1 -> +1 bounce.
//   Honours TICK_LATCH_EN the same way the design does.

module tb_square_animator;

  localparam int W      = 21;  // {busy, frame_done, plot, colour[2:0], x[7:0], y[6:0]}
  localparam int SIZE   = 4;
  localparam int X_MAX  = 160;
  localparam int Y_MAX  = 120;
  localparam int STEP   = 1;
  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic tick_m, tick_b, tick_s;
  always #5 clock = ~clock;

  logic [7:0] m_x, b_x, s_x;
  logic [6:0] m_y, b_y, s_y;
  logic [2:0] m_col, b_col, s_col, m_st, b_st, s_st;
  logic m_plot, m_busy, m_fd, b_plot, b_busy, b_fd, s_plot, s_busy, s_fd;

  square_animator u_main (
    .clock(clock), .reset(reset), .tick_en(tick_m),
    .x_out(m_x), .y_out(m_y), .colour(m_col), .plot(m_plot),
    .busy(m_busy), .frame_done(m_fd), .state_dbg(m_st));

  square_animator #(.X_INIT(156), .Y_INIT(116)) u_bnc (
    .clock(clock), .reset(reset), .tick_en(tick_b),
    .x_out(b_x), .y_out(b_y), .colour(b_col), .plot(b_plot),
    .busy(b_busy), .frame_done(b_fd), .state_dbg(b_st));

  square_animator #(.X_MAX(12), .Y_MAX(12), .X_INIT(7), .Y_INIT(7), .STEP(2)) u_stp (
    .clock(clock), .reset(reset), .tick_en(tick_s),
    .x_out(s_x), .y_out(s_y), .colour(s_col), .plot(s_plot),
    .busy(s_busy), .frame_done(s_fd), .state_dbg(s_st));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int mx, my, mdx, mdy;
  bit m_pend;

  task automatic check_rec(input string name, input logic [W-1:0] act,
                           input logic [W-1:0] exp, input bit full);
    logic [W-1:0] mask;
    mask = full ? {W{1'b1}} : {3'b111, {(W-3){1'b0}}};
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s @%0t: got busy=%b fd=%b plot=%b col=%0d x=%0d y=%0d, expected busy=%b fd=%b plot=%b col=%0d x=%0d y=%0d (pixel fields %s)",
               name, $time, act[20], act[19], act[18], act[17:15], act[14:7], act[6:0],
               exp[20], exp[19], exp[18], exp[17:15], exp[14:7], exp[6:0], full ? "checked" : "ignored");
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] rec(input bit b, input bit fd, input bit p,
                                       input logic [2:0] c, input int x, input int y);
    return {b, fd, p, c, 8'(x), 7'(y)};
  endfunction

  task automatic move(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + STEP > lim - SIZE) begin d = -1; p = p - STEP; end
      else p = p + STEP;
    end else begin
      if (p < STEP) begin d = 1; p = p + STEP; end
      else p = p - STEP;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pend = 0;
    mx = 0; my = 0; mdx = 1; mdy = 1;
  endtask

  // One whole frame as the cycle-by-cycle outputs that follow the start edge.
  task automatic push_frame();
    for (int i = 0; i < SIZE * SIZE; i++)
      exp_q.push_back(rec(1, 0, 1, BG, mx + i % SIZE, my + i / SIZE));
    exp_q.push_back(rec(1, 0, 0, 3'd0, 0, 0));
    move(mx, mdx, X_MAX);
    move(my, mdy, Y_MAX);
    for (int i = 0; i < SIZE * SIZE; i++)
      exp_q.push_back(rec(1, 0, 1, FG, mx + i % SIZE, my + i / SIZE));
    exp_q.push_back(rec(1, 1, 0, 3'd0, 0, 0));
  endtask

  // ---------------- driver: one clock, then check u_main ----------------
  task automatic cycle();
    logic [W-1:0] act, exp;
    bit t, r, was_idle;
    t = tick_m;
    r = reset;
    @(posedge clock);
    #1;
    act = {m_busy, m_fd, m_plot, m_col, m_x, m_y};
    if (!r) begin
      model_reset();
      check_rec("reset_outputs", act, '0, 1);
    end else begin
      was_idle = (exp_q.size() == 0);
      exp = was_idle ? rec(0, 0, 0, 3'd0, 0, 0) : exp_q.pop_front();
      check_rec(was_idle ? "idle" : "frame_stream", act, exp, exp[18]);
      if (was_idle) begin
        if (t) push_frame();
      end
`ifdef TICK_LATCH_EN
      else if (exp[19]) begin
        if (m_pend || t) begin m_pend = 0; push_frame(); end
      end else if (t) m_pend = 1;
`endif
    end
  endtask

  // Runs one frame on u_bnc (which=1) or u_stp (which=2) and returns the
  // first DRAW pixel, i.e. the new top-left corner.
  task automatic frame_origin(input int which, output int ox, output int oy, output int op);
    if (which == 1) tick_b = 1'b1; else tick_s = 1'b1;
    cycle();
    tick_b = 1'b0; tick_s = 1'b0;
    repeat (SIZE * SIZE + 2) cycle();
    if (which == 1) begin ox = b_x; oy = b_y; op = b_plot; end
    else            begin ox = s_x; oy = s_y; op = s_plot; end
    repeat (SIZE * SIZE + 1) cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst;
    logic tick;
    logic plot;
    logic busy;
    logic fd;
    int   x;
    int   y;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int fd_at, bl_at, n_fd, n_blow, ox, oy, op;
    int s_exp[5];
    logic [W-1:0] act_v, exp_v;

    reset = 1'b0; tick_m = 1'b0; tick_b = 1'b0; tick_s = 1'b0;
    model_reset();

    // reset held with tick_en high, start a frame, then reset mid-frame
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      reset  = vecs[i].rst;
      tick_m = vecs[i].tick;
      cycle();
      act_v = {m_busy, m_fd, m_plot, m_col, m_x, m_y};
      exp_v = rec(vecs[i].busy, vecs[i].fd, vecs[i].plot, 3'd0, vecs[i].x, vecs[i].y);
      check_rec($sformatf("vec%0d", i), act_v, exp_v, !vecs[i].rst || vecs[i].plot);
    end
    tick_m = 1'b0;

    // single tick from (0,0): frame_done at cycle 34, busy low at 35
    tick_m = 1'b1;
    cycle();
    tick_m = 1'b0;
    fd_at = -1; bl_at = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (m_fd && fd_at < 0) fd_at = i;
      if (!m_busy && bl_at < 0) bl_at = i;
    end
    check_int("frame_done_cycle", fd_at, 2 * SIZE * SIZE + 2);
    check_int("busy_low_cycle", bl_at, 2 * SIZE * SIZE + 3);

    // tick arriving at cycle 10 of a frame
    tick_m = 1'b1;
    cycle();
    tick_m = 1'b0;
    n_fd = 0; n_blow = 0;
    for (int i = 1; i <= 80; i++) begin
      tick_m = (i == 10);
      cycle();
      if (m_fd) n_fd++;
      if (!m_busy && i <= 2 * (2 * SIZE * SIZE + 2)) n_blow++;
    end
    tick_m = 1'b0;
`ifdef TICK_LATCH_EN
    check_int("latched_frames", n_fd, 2);
    check_int("busy_gap_cycles", n_blow, 0);
`else
    check_int("latched_frames", n_fd, 1);
    check_int("busy_gap_cycles", n_blow, 2 * SIZE * SIZE + 2);
`endif

    // reset at cycle 20 of a frame, then restart from (X_INIT,Y_INIT)
    tick_m = 1'b1;
    cycle();
    tick_m = 1'b0;
    repeat (19) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check_int("plot_after_reset", m_plot, 0);
    cycle();
    tick_m = 1'b1;
    cycle();
    tick_m = 1'b0;
    cycle();
    check_int("restart_x", m_x, 0);
    check_int("restart_y", m_y, 0);
    check_int("restart_plot", m_plot, 1);

    // randomized tick_en, including ticks while busy
    for (int i = 0; i < 700; i++) begin
      tick_m = ($urandom_range(0, 7) == 0);
      cycle();
    end
    tick_m = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle();
    check_int("model_drained", exp_q.size(), 0);
    cycle();

    // right/bottom bounce from (156,116)
    frame_origin(1, ox, oy, op);
    check_int("bnc1_plot", op, 1);
    check_int("bnc1_x", ox, 155);
    check_int("bnc1_y", oy, 115);
    frame_origin(1, ox, oy, op);
    check_int("bnc2_x", ox, 154);
    check_int("bnc2_y", oy, 114);

    // STEP=2 on a 12x12 field from (7,7): 5,3,1 then bounce to 3,5
    s_exp = '{5, 3, 1, 3, 5};
    for (int f = 0; f < 5; f++) begin
      frame_origin(2, ox, oy, op);
      check_int($sformatf("stp%0d_plot", f), op, 1);
      check_int($sformatf("stp%0d_x", f), ox, s_exp[f]);
      check_int($sformatf("stp%0d_y", f), oy, s_exp[f]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
